// File: rtl/nvm_flash_ctrl.sv
// Flash-style NVM: 1-cycle registered read, timed bit-clearing PROGRAM, timed page ERASE.
// The array has no reset; it keeps its content across rst_n.
module nvm_flash_ctrl #(
    parameter int    ADDR_WIDTH   = 10,
    parameter int    DATA_WIDTH   = 32,
    parameter int    PAGE_WORDS   = 16,
    parameter int    PROG_CYCLES  = 8,
    parameter int    ERASE_CYCLES = 32,
    parameter string INIT_FILE    = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic [1:0]              cmd,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wd,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   rd,
    output logic                    rvalid,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int MAXC   = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int CW     = $clog2(MAXC) + 1;

    localparam logic [CW-1:0]         PROG_LAST   = CW'(PROG_CYCLES - 1);
    localparam logic [CW-1:0]         ERASE_LAST  = CW'(ERASE_CYCLES - 1);
    localparam logic [CW-1:0]         ERASE_START = CW'(ERASE_CYCLES - PAGE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] PAGE_MASK   = ADDR_WIDTH'(PAGE_WORDS - 1);

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_PROG  = 2'b01;
    localparam logic [1:0] CMD_ERASE = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_PROG, S_ERASE} state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wd_q;
    logic [NBYTES-1:0]       be_q;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic                    rvalid_q, busy_q, done_q, err_q;

    logic                    prog_we, ers_we;
    logic [ADDR_WIDTH-1:0]   ers_addr;
    logic [DATA_WIDTH-1:0]   prog_keep;
    logic [DATA_WIDTH-1:0]   prog_word_d;

    // Array writes derive only from reset-cleared state, so an abort never writes.
    always_comb begin
        prog_we  = (state_q == S_PROG)  && (cnt_q == PROG_LAST);
        ers_we   = (state_q == S_ERASE) && (cnt_q >= ERASE_START);
        ers_addr = addr_q + ADDR_WIDTH'(cnt_q - ERASE_START);
        prog_keep = '1;
        for (int b = 0; b < NBYTES; b++) begin
            if (be_q[b]) prog_keep[b*8 +: 8] = wd_q[b*8 +: 8];
        end
        prog_word_d = mem[addr_q] & prog_keep;
    end

    always_ff @(posedge clk) begin
        if (prog_we) mem[addr_q]   <= prog_word_d;
        if (ers_we)  mem[ers_addr] <= '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wd_q     <= '0;
            be_q     <= '0;
            rd_q     <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        case (cmd)
                            CMD_READ: begin
                                rd_q     <= mem[addr];
                                rvalid_q <= 1'b1;
                            end
                            CMD_PROG: begin
                                state_q <= S_PROG;
                                busy_q  <= 1'b1;
                                cnt_q   <= '0;
                                addr_q  <= addr;
                                wd_q    <= wd;
                                be_q    <= be;
                            end
                            CMD_ERASE: begin
                                state_q <= S_ERASE;
                                busy_q  <= 1'b1;
                                cnt_q   <= '0;
                                addr_q  <= addr & ~PAGE_MASK;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                S_PROG: begin
                    if (req) err_q <= 1'b1;
                    if (cnt_q == PROG_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_ERASE: begin
                    if (req) err_q <= 1'b1;
                    if (cnt_q == ERASE_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd     = rd_q;
    assign rvalid = rvalid_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
endmodule

// File: tb/tb_nvm_flash_ctrl.sv
// Directed bench for nvm_flash_ctrl: read latency, bit-clearing program, page erase,
// command rejection, partial erase on reset, and back-to-back acceptance.
module tb_nvm_flash_ctrl;
    localparam logic [1:0] C_RD = 2'b00;
    localparam logic [1:0] C_PG = 2'b01;
    localparam logic [1:0] C_ER = 2'b10;
    localparam logic [1:0] C_XX = 2'b11;
    localparam int P_CYC = 8;
    localparam int E_CYC = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [1:0]  cmd;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        rvalid, busy, done, err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nvm_flash_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .addr(addr), .wd(wd), .be(be),
        .rd(rd), .rvalid(rvalid), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] c, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] b);
        req = 1'b1; cmd = c; addr = a; wd = d; be = b;
        tick();
        req = 1'b0; cmd = 2'b00; addr = '0; wd = '0; be = '0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic op(input string tag, input logic [1:0] c, input logic [9:0] a,
                      input logic [31:0] d, input logic [3:0] b, input int exp_cyc);
        int n;
        issue(c, a, d, b);
        wait_idle(n);
        chk({tag, "_cycles"}, n, exp_cyc);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic rdchk(input string tag, input logic [9:0] a, input logic [31:0] exp);
        issue(C_RD, a, 32'd0, 4'd0);
        chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        chk(tag, rd, exp);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; req = 1'b0; cmd = '0; addr = '0; wd = '0; be = '0;
        repeat (3) tick();
        chk("rst_rd", rd, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Known starting image: erase pages 0..3.
        op("er_p0", C_ER, 10'd3,  32'd0, 4'd0, E_CYC);
        op("er_p1", C_ER, 10'd16, 32'd0, 4'd0, E_CYC);
        op("er_p2", C_ER, 10'd32, 32'd0, 4'd0, E_CYC);
        op("er_p3", C_ER, 10'd48, 32'd0, 4'd0, E_CYC);

        // T1 read latency and rd hold
        op("pg5", C_PG, 10'd5, 32'hA5A5A5A5, 4'hF, P_CYC);
        rdchk("t1_rd5", 10'd5, 32'hA5A5A5A5);
        tick();
        chk("t1_rvalid_pulse", {31'd0, rvalid}, 32'd0);
        chk("t1_rd_hold", rd, 32'hA5A5A5A5);

        // T2 program AND semantics
        rdchk("t2_rd3_erased", 10'd3, 32'hFFFFFFFF);
        op("t2_pgA", C_PG, 10'd3, 32'h12345678, 4'b0011, P_CYC);
        rdchk("t2_rd3_a", 10'd3, 32'hFFFF5678);
        op("t2_pgB", C_PG, 10'd3, 32'h0000FFFF, 4'b1111, P_CYC);
        rdchk("t2_rd3_b", 10'd3, 32'h00005678);
        op("t2_pg_be0", C_PG, 10'd3, 32'h00000000, 4'b0000, P_CYC);
        rdchk("t2_rd3_be0", 10'd3, 32'h00005678);

        // T3 page erase with neighbours
        op("t3_pg15", C_PG, 10'd15, 32'h0F0F0F0F, 4'hF, P_CYC);
        op("t3_pg32", C_PG, 10'd32, 32'h12121212, 4'hF, P_CYC);
        for (int i = 16; i < 32; i++) begin
            issue(C_PG, 10'(i), 32'h5A5A0000 | 32'(i), 4'hF);
            wait_idle(n);
        end
        rdchk("t3_pre21", 10'd21, 32'h5A5A0015);
        op("t3_erase", C_ER, 10'd21, 32'd0, 4'd0, E_CYC);
        for (int i = 16; i < 32; i++) rdchk($sformatf("t3_w%0d", i), 10'(i), 32'hFFFFFFFF);
        rdchk("t3_w15", 10'd15, 32'h0F0F0F0F);
        rdchk("t3_w32", 10'd32, 32'h12121212);

        // T4 rejection while busy and reserved command
        issue(C_PG, 10'd40, 32'hCAFEBABE, 4'hF);
        tick();
        tick();
        req = 1'b1; cmd = C_RD; addr = 10'd40;
        tick();
        req = 1'b0;
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_no_rvalid", {31'd0, rvalid}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t4_err_pulse", {31'd0, err}, 32'd0);
        wait_idle(n);
        chk("t4_done", {31'd0, done}, 32'd1);
        rdchk("t4_rd40", 10'd40, 32'hCAFEBABE);
        issue(C_XX, 10'd0, 32'd0, 4'd0);
        chk("t4_rsv_err", {31'd0, err}, 32'd1);
        chk("t4_rsv_busy", {31'd0, busy}, 32'd0);
        chk("t4_rsv_rvalid", {31'd0, rvalid}, 32'd0);

        // Rejected req on the final busy cycle: done and err together
        issue(C_PG, 10'd41, 32'h00000000, 4'hF);
        repeat (P_CYC - 1) tick();
        req = 1'b1; cmd = C_RD; addr = 10'd41;
        tick();
        req = 1'b0;
        chk("de_done", {31'd0, done}, 32'd1);
        chk("de_err", {31'd0, err}, 32'd1);
        chk("de_busy", {31'd0, busy}, 32'd0);
        chk("de_rvalid", {31'd0, rvalid}, 32'd0);
        rdchk("de_rd41", 10'd41, 32'h00000000);

        // T6 read accepted in the done cycle
        issue(C_PG, 10'd42, 32'h11111111, 4'hF);
        wait_idle(n);
        chk("t6_done", {31'd0, done}, 32'd1);
        rdchk("t6_rd42", 10'd42, 32'h11111111);

        // T5 reset mid-erase leaves a deterministic partial erase
        for (int i = 48; i < 64; i++) begin
            issue(C_PG, 10'(i), 32'h30000000 + 32'(i - 48), 4'hF);
            wait_idle(n);
        end
        issue(C_ER, 10'd50, 32'd0, 4'd0);
        repeat (20) tick();
        chk("t5_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", {31'd0, busy}, 32'd0);
        chk("t5_done_rst", {31'd0, done}, 32'd0);
        chk("t5_rd_rst", rd, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 48; i < 52; i++) rdchk($sformatf("t5_w%0d", i), 10'(i), 32'hFFFFFFFF);
        for (int i = 52; i < 64; i++)
            rdchk($sformatf("t5_w%0d", i), 10'(i), 32'h30000000 + 32'(i - 48));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
